// File: rtl/mux4to1_stream.sv
// Four-channel valid/ready merge into one registered output stream, with round-robin
// arbitration between packets and a lock that keeps a multi-beat packet contiguous.
module mux4to1_stream #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Data_in_0,
  input  logic [WIDTH-1:0] Data_in_1,
  input  logic [WIDTH-1:0] Data_in_2,
  input  logic [WIDTH-1:0] Data_in_3,
  input  logic             Valid_in_0,
  input  logic             Valid_in_1,
  input  logic             Valid_in_2,
  input  logic             Valid_in_3,
  input  logic             Last_in_0,
  input  logic             Last_in_1,
  input  logic             Last_in_2,
  input  logic             Last_in_3,
  output logic             Ready_out_0,
  output logic             Ready_out_1,
  output logic             Ready_out_2,
  output logic             Ready_out_3,
  output logic [WIDTH-1:0] Data_out,
  output logic [1:0]       Sel_out,
  output logic             Last_out,
  output logic             Valid_out,
  input  logic             Ready_in
);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e           r_state, w_state_next;
  logic [1:0]       r_ptr, w_ptr_next;
  logic [1:0]       r_lock_sel, w_lock_sel_next;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_sel;
  logic             r_last;
  logic             r_valid;

  logic [WIDTH-1:0] w_data [4];
  logic [3:0]       w_valid;
  logic [3:0]       w_last;
  logic [1:0]       w_grant;
  logic             w_any;
  logic             w_free;
  logic             w_xfer;
  logic [3:0]       w_ready;

  assign w_data[0] = Data_in_0;
  assign w_data[1] = Data_in_1;
  assign w_data[2] = Data_in_2;
  assign w_data[3] = Data_in_3;
  assign w_valid   = {Valid_in_3, Valid_in_2, Valid_in_1, Valid_in_0};
  assign w_last    = {Last_in_3, Last_in_2, Last_in_1, Last_in_0};

  // Search offsets high to low so the nearest valid channel after ptr wins.
  always_comb begin
    w_grant = r_ptr;
    w_any   = 1'b0;
    if (r_state == StLocked) begin
      w_grant = r_lock_sel;
      w_any   = w_valid[r_lock_sel];
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (w_valid[r_ptr + 2'(i)]) begin
          w_grant = r_ptr + 2'(i);
          w_any   = 1'b1;
        end
      end
    end
  end

  assign w_free  = !r_valid || Ready_in;
  assign w_xfer  = w_free && w_any;
  // Gated by reset so no channel sees an accept while the block is held in reset.
  assign w_ready = (Reset_n && w_xfer) ? (4'b0001 << w_grant) : 4'b0000;

  assign Ready_out_0 = w_ready[0];
  assign Ready_out_1 = w_ready[1];
  assign Ready_out_2 = w_ready[2];
  assign Ready_out_3 = w_ready[3];

  always_comb begin
    w_state_next    = r_state;
    w_ptr_next      = r_ptr;
    w_lock_sel_next = r_lock_sel;
    if (w_xfer) begin
      unique case (r_state)
        StIdle: begin
          if (w_last[w_grant]) begin
            w_ptr_next = w_grant + 2'd1;
          end else begin
            w_state_next    = StLocked;
            w_lock_sel_next = w_grant;
          end
        end
        StLocked: begin
          if (w_last[w_grant]) begin
            w_state_next = StIdle;
            w_ptr_next   = w_grant + 2'd1;
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= StIdle;
      r_ptr      <= 2'd0;
      r_lock_sel <= 2'd0;
    end else begin
      r_state    <= w_state_next;
      r_ptr      <= w_ptr_next;
      r_lock_sel <= w_lock_sel_next;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_data  <= '0;
      r_sel   <= 2'd0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_data  <= w_data[w_grant];
      r_sel   <= w_grant;
      r_last  <= w_last[w_grant];
      r_valid <= 1'b1;
    end else if (Ready_in) begin
      r_valid <= 1'b0;
    end
  end

  assign Data_out  = r_data;
  assign Sel_out   = r_sel;
  assign Last_out  = r_last;
  assign Valid_out = r_valid;

endmodule

// File: tb/tb_mux4to1_stream.sv
// Directed bench for mux4to1_stream: round robin, packet lock, backpressure, wrap,
// locked-channel stall and asynchronous reset mid-packet.
module tb_mux4to1_stream;

  logic       Clk;
  logic       Reset_n;
  logic [7:0] din [4];
  logic [3:0] vin;
  logic [3:0] lin;
  logic       ro0, ro1, ro2, ro3;
  logic [7:0] Data_out;
  logic [1:0] Sel_out;
  logic       Last_out;
  logic       Valid_out;
  logic       Ready_in;

  int n_cmp  = 0;
  int n_fail = 0;

  mux4to1_stream #(.WIDTH(8)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Data_in_0   (din[0]),
    .Data_in_1   (din[1]),
    .Data_in_2   (din[2]),
    .Data_in_3   (din[3]),
    .Valid_in_0  (vin[0]),
    .Valid_in_1  (vin[1]),
    .Valid_in_2  (vin[2]),
    .Valid_in_3  (vin[3]),
    .Last_in_0   (lin[0]),
    .Last_in_1   (lin[1]),
    .Last_in_2   (lin[2]),
    .Last_in_3   (lin[3]),
    .Ready_out_0 (ro0),
    .Ready_out_1 (ro1),
    .Ready_out_2 (ro2),
    .Ready_out_3 (ro3),
    .Data_out    (Data_out),
    .Sel_out     (Sel_out),
    .Last_out    (Last_out),
    .Valid_out   (Valid_out),
    .Ready_in    (Ready_in)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic v, input logic [7:0] d, input logic l);
    vin[k] = v;
    din[k] = d;
    lin[k] = l;
  endtask

  task automatic chk_rdy(input string tag, input logic [3:0] exp);
    #1;
    check(tag, {28'b0, ro3, ro2, ro1, ro0}, {28'b0, exp});
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic [1:0] s, input logic l);
    check({tag, "_valid"}, {31'b0, Valid_out}, {31'b0, v});
    check({tag, "_data"}, {24'b0, Data_out}, {24'b0, d});
    check({tag, "_sel"}, {30'b0, Sel_out}, {30'b0, s});
    check({tag, "_last"}, {31'b0, Last_out}, {31'b0, l});
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vin      = 4'b0;
    lin      = 4'b0;
    for (int k = 0; k < 4; k++) din[k] = 8'h00;
    Ready_in = 1'b1;
    Reset_n  = 1'b1;
    #2 Reset_n = 1'b0;
    #1;
    chk_out("reset", 1'b0, 8'h00, 2'd0, 1'b0);
    check("reset_rdy", {28'b0, ro3, ro2, ro1, ro0}, 32'd0);
    tick();
    Reset_n = 1'b1;

    // Single-beat round robin across all four channels; ends with ptr back at 0.
    for (int k = 0; k < 4; k++) set_ch(k, 1'b1, 8'((k + 1) * 16), 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk_rdy("rr_rdy", 4'(1 << (i % 4)));
      tick();
      chk_out("rr", 1'b1, 8'(((i % 4) + 1) * 16), 2'(i % 4), 1'b1);
    end
    vin = 4'b0;
    chk_rdy("rr_drain_rdy", 4'b0000);
    tick();
    chk_out("rr_drain", 1'b0, 8'h40, 2'd3, 1'b1);

    // Packet lock: ch0 wins first, then ch2 holds the output for three beats.
    set_ch(0, 1'b1, 8'h0F, 1'b1);
    set_ch(2, 1'b1, 8'hA1, 1'b0);
    chk_rdy("lk0_rdy", 4'b0001);
    tick();
    chk_out("lk0", 1'b1, 8'h0F, 2'd0, 1'b1);
    chk_rdy("lk1_rdy", 4'b0100);
    tick();
    chk_out("lk1", 1'b1, 8'hA1, 2'd2, 1'b0);
    set_ch(2, 1'b1, 8'hA2, 1'b0);
    chk_rdy("lk2_rdy", 4'b0100);
    tick();
    chk_out("lk2", 1'b1, 8'hA2, 2'd2, 1'b0);
    set_ch(2, 1'b1, 8'hA3, 1'b1);
    chk_rdy("lk3_rdy", 4'b0100);
    tick();
    chk_out("lk3", 1'b1, 8'hA3, 2'd2, 1'b1);
    vin[2] = 1'b0;
    chk_rdy("lk4_rdy", 4'b0001);
    tick();
    chk_out("lk4", 1'b1, 8'h0F, 2'd0, 1'b1);
    vin = 4'b0;
    tick();
    check("lk_drain_valid", {31'b0, Valid_out}, 32'd0);

    // Backpressure: ptr=1, ch1 captured then held for five stalled cycles.
    set_ch(1, 1'b1, 8'h55, 1'b1);
    chk_rdy("bp0_rdy", 4'b0010);
    tick();
    chk_out("bp0", 1'b1, 8'h55, 2'd1, 1'b1);
    Ready_in = 1'b0;
    set_ch(1, 1'b1, 8'h66, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk_rdy("bp_hold_rdy", 4'b0000);
      tick();
      chk_out("bp_hold", 1'b1, 8'h55, 2'd1, 1'b1);
    end
    Ready_in = 1'b1;
    chk_rdy("bp_resume_rdy", 4'b0010);
    tick();
    chk_out("bp_resume", 1'b1, 8'h66, 2'd1, 1'b1);
    vin = 4'b0;
    tick();
    check("bp_drain_valid", {31'b0, Valid_out}, 32'd0);

    // Wrap: ptr=2, ch3 single beat pushes ptr to 0, then ch0 alone.
    set_ch(3, 1'b1, 8'h33, 1'b1);
    chk_rdy("wr0_rdy", 4'b1000);
    tick();
    chk_out("wr0", 1'b1, 8'h33, 2'd3, 1'b1);
    vin[3] = 1'b0;
    set_ch(0, 1'b1, 8'h01, 1'b1);
    chk_rdy("wr1_rdy", 4'b0001);
    tick();
    chk_out("wr1", 1'b1, 8'h01, 2'd0, 1'b1);
    vin = 4'b0;
    chk_rdy("idle_rdy", 4'b0000);
    tick();
    chk_out("idle", 1'b0, 8'h01, 2'd0, 1'b1);

    // Locked stall: ptr=1, ch1 opens a packet then pauses while ch3 waits.
    set_ch(1, 1'b1, 8'hB1, 1'b0);
    chk_rdy("st0_rdy", 4'b0010);
    tick();
    chk_out("st0", 1'b1, 8'hB1, 2'd1, 1'b0);
    vin[1] = 1'b0;
    set_ch(3, 1'b1, 8'hC3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk_rdy("st_wait_rdy", 4'b0000);
      tick();
      check("st_wait_valid", {31'b0, Valid_out}, 32'd0);
    end
    set_ch(1, 1'b1, 8'hB2, 1'b1);
    chk_rdy("st1_rdy", 4'b0010);
    tick();
    chk_out("st1", 1'b1, 8'hB2, 2'd1, 1'b1);
    vin[1] = 1'b0;
    chk_rdy("st2_rdy", 4'b1000);
    tick();
    chk_out("st2", 1'b1, 8'hC3, 2'd3, 1'b1);

    // Reset mid-packet: lock onto ch0, then assert reset between edges.
    vin[3] = 1'b0;
    set_ch(0, 1'b1, 8'hD0, 1'b0);
    chk_rdy("rm0_rdy", 4'b0001);
    tick();
    chk_out("rm0", 1'b1, 8'hD0, 2'd0, 1'b0);
    Reset_n = 1'b0;
    #1;
    chk_out("rm_async", 1'b0, 8'h00, 2'd0, 1'b0);
    check("rm_async_rdy", {28'b0, ro3, ro2, ro1, ro0}, 32'd0);
    vin = 4'b0;
    tick();
    Reset_n = 1'b1;
    set_ch(2, 1'b1, 8'h77, 1'b1);
    chk_rdy("rm1_rdy", 4'b0100);
    tick();
    chk_out("rm1", 1'b1, 8'h77, 2'd2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
